pmem_arbiter: RTL and testbench
===============================

PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, physical address width in bits.
REQ-002 Parameter LINE_W, default 256, cache line width in bits.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 i_pmem_read  input  1  icache line-fill request.
REQ-006 i_pmem_address  input  ADDR_W  icache line address.
REQ-007 i_pmem_rdata  output  LINE_W  fill data to icache.
REQ-008 i_pmem_resp  output  1  one-cycle completion pulse to icache.
REQ-009 d_pmem_read  input  1  dcache line-fill request.
REQ-010 d_pmem_write  input  1  dcache write-back request.
REQ-011 d_pmem_address  input  ADDR_W  dcache line address.
REQ-012 d_pmem_wdata  input  LINE_W  dcache write-back data.
REQ-013 d_pmem_rdata  output  LINE_W  fill data to dcache.
REQ-014 d_pmem_resp  output  1  one-cycle completion pulse to dcache.
REQ-015 pmem_read / pmem_write  output  1 each  physical memory command, held until pmem_resp.
REQ-016 pmem_address  output  ADDR_W; pmem_wdata  output  LINE_W; pmem_rdata  input  LINE_W; pmem_resp  input  1.

Function
REQ-017 The FSM SHALL have states IDLE, I_XFER, D_XFER.
- IDLE: no pmem command driven; requests sampled.
- I_XFER: pmem_read=1, address from the latched icache request.
- D_XFER: pmem_read or pmem_write per latched dcache opcode.
REQ-018 In IDLE, the block SHALL move to I_XFER or D_XFER on the next edge if the corresponding request is high, latching address, wdata and opcode at that edge.
REQ-019 The pmem command SHALL be asserted the cycle after the request is first seen in IDLE (one-cycle grant latency) and held constant until pmem_resp.
REQ-020 If d_pmem_read and d_pmem_write are both high, the transaction SHALL be a write.
REQ-021 pmem_resp in I_XFER or D_XFER SHALL be forwarded combinationally, same cycle, to only the granted requester's resp. pmem_rdata SHALL pass combinationally to both rdata outputs. The FSM SHALL then return to IDLE.
REQ-022 In IDLE, pmem_resp SHALL be ignored, and i/d resp SHALL stay 0.
REQ-023 Requests deasserting mid-transfer SHALL NOT abort it. The transfer completes, and its resp pulse is still forwarded.
REQ-024 A requester still asserting after its resp SHALL be re-arbitrated from IDLE. There is at least one IDLE cycle between transfers.
REQ-025 pmem_read and pmem_write SHALL never be high simultaneously.

Reset
REQ-026 Asserting rst SHALL force IDLE immediately, regardless of clk.
REQ-027 While rst is asserted, all outputs SHALL be 0: commands, resps, pmem_address, pmem_wdata.
REQ-028 Reset during a transfer SHALL abandon it without a resp to either cache.
REQ-029 Latched address, wdata, opcode and the priority flag SHALL clear to 0 on reset.

Configuration
REQ-030 Macro PMEM_ARB_ROUND_ROBIN_EN SHALL select the priority policy:
- Undefined: fixed priority, dcache wins a simultaneous request.
- Defined: a 1-bit last-grant flag gives the other requester priority on a simultaneous request. The flag updates on each grant and resets to "last=icache", so dcache wins first.

Verification
REQ-031 Icache only: i_pmem_read=1 at address 0x0000_0100, pmem_resp after 5 cycles -> pmem_read=1 from cycle+1, pmem_address=0x100, exactly one i_pmem_resp pulse, d_pmem_resp=0 throughout.
REQ-032 Simultaneous i_pmem_read and d_pmem_write (address 0x2000, wdata all 0xA5) -> D_XFER first with pmem_write=1, then I_XFER after one IDLE cycle. With ROUND_ROBIN_EN, a second simultaneous pair grants icache first.
REQ-033 d_pmem_address changes to 0x3000 mid-transfer -> pmem_address stays at the latched 0x2000 until pmem_resp.
REQ-034 rst asserted 2 cycles into D_XFER -> outputs 0 immediately, no d_pmem_resp, and a subsequent request is granted normally.
REQ-035 Stray pmem_resp pulse in IDLE -> no i_pmem_resp or d_pmem_resp, and the state stays IDLE.
REQ-036 Back-to-back icache requests held high -> exactly one IDLE cycle between consecutive pmem_read assertions.

Source files
------------

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Brief    : Arbitrates icache fills and dcache fills/write-backs onto a single
//            physical memory port. Define PMEM_ARB_ROUND_ROBIN_EN for
//            alternating priority; otherwise dcache has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_XFER = 2'd1;
    localparam logic [1:0] D_XFER = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_write;
    logic              w_d_req;
    logic              w_d_prio;
    logic              w_grant_d;
    logic              w_grant_i;

`ifdef PMEM_ARB_ROUND_ROBIN_EN
    // 0 = icache was granted last (reset value), so dcache wins first.
    logic r_last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_d <= 1'b0;
        end else if (r_state == IDLE && (w_grant_d || w_grant_i)) begin
            r_last_d <= w_grant_d;
        end
    end

    assign w_d_prio = ~r_last_d;
`else
    assign w_d_prio = 1'b1;
`endif

    always_comb begin
        w_d_req   = d_pmem_read | d_pmem_write;
        w_grant_d = w_d_req & (~i_pmem_read | w_d_prio);
        w_grant_i = i_pmem_read & ~w_grant_d;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next_state = D_XFER;
                end else if (w_grant_i) begin
                    w_next_state = I_XFER;
                end
            end
            I_XFER, D_XFER: begin
                if (pmem_resp) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Request is captured on the grant edge so the command stays stable even
    // if the requester changes or drops its inputs mid-transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_grant_d) begin
                r_addr  <= d_pmem_address;
                r_wdata <= d_pmem_wdata;
                r_write <= d_pmem_write;
            end else if (w_grant_i) begin
                r_addr  <= i_pmem_address;
                r_wdata <= '0;
                r_write <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (r_state)
            I_XFER: begin
                pmem_read    = 1'b1;
                pmem_address = r_addr;
                i_pmem_resp  = pmem_resp;
            end
            D_XFER: begin
                pmem_read    = ~r_write;
                pmem_write   = r_write;
                pmem_address = r_addr;
                pmem_wdata   = r_wdata;
                d_pmem_resp  = pmem_resp;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Brief    : Self-checking bench for pmem_arbiter (directed scenarios plus
//            randomized traffic against a transaction-level reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read;
    logic          d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_cmp = 0;
    int n_bad = 0;

    pmem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Transaction-level model: one outstanding transfer, who owns it, and what it carries.
    bit            m_busy;
    bit            m_is_d;
    bit            m_write;
    bit            m_last_d;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic bit dcache_wins(bit ir, bit dr);
        if (!dr) return 1'b0;
        if (!ir) return 1'b1;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        return !m_last_d;
`else
        return 1'b1;
`endif
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_is_d = 0; m_write = 0; m_last_d = 0; m_addr = '0; m_wdata = '0;
    endfunction

    function automatic void model_edge();
        if (m_busy) begin
            if (pmem_resp) m_busy = 0;
        end else if (i_pmem_read || d_pmem_read || d_pmem_write) begin
            m_busy   = 1;
            m_is_d   = dcache_wins(i_pmem_read, d_pmem_read || d_pmem_write);
            m_last_d = m_is_d;
            if (m_is_d) begin
                m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_write = d_pmem_write;
            end else begin
                m_addr = i_pmem_address; m_wdata = '0; m_write = 0;
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = rand_line();
        model_reset();
        @(negedge clk);
        i_pmem_read = 1; d_pmem_write = 1; pmem_resp = 1;
        d_pmem_address = 32'hDEAD_0000; d_pmem_wdata = rand_line();
        @(negedge clk);
        n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL reset_read: got %0b want 0", pmem_read); end
        n_cmp++; if (pmem_write !== 1'b0) begin n_bad++; $display("FAIL reset_write: got %0b want 0", pmem_write); end
        n_cmp++; if (i_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL reset_iresp: got %0b want 0", i_pmem_resp); end
        n_cmp++; if (d_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL reset_dresp: got %0b want 0", d_pmem_resp); end
        n_cmp++; if (pmem_address !== '0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", pmem_address); end
        n_cmp++; if (pmem_wdata !== '0) begin n_bad++; $display("FAIL reset_wdata: got %h want 0", pmem_wdata); end
        idle_inputs();
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_icache_only();
        int            i_cnt = 0;
        int            d_cnt = 0;
        logic [LW-1:0] line;
        i_pmem_read = 1; i_pmem_address = 32'h0000_0100;
        #1;
        n_cmp++; if (pmem_read !== 1'b0) begin n_bad++; $display("FAIL ionly_latency: got %0b want 0", pmem_read); end
        tick();
        i_pmem_read = 0;
        for (int k = 0; k < 8; k++) begin
            pmem_resp = (k == 4);
            line = rand_line();
            pmem_rdata = line;
            #1;
            if (i_pmem_resp === 1'b1) i_cnt++;
            if (d_pmem_resp !== 1'b0) d_cnt++;
            n_cmp++;
            if (pmem_read !== (k <= 4) || pmem_write !== 1'b0 || (k <= 4 && pmem_address !== 32'h100)) begin
                n_bad++;
                $display("FAIL ionly_cmd[%0d]: got rd=%0b wr=%0b addr=%h want rd=%0b wr=0 addr=100", k, pmem_read, pmem_write, pmem_address, k <= 4);
            end
            if (k == 4) begin
                n_cmp++; if (i_pmem_rdata !== line) begin n_bad++; $display("FAIL ionly_rdata: got %h want %h", i_pmem_rdata, line); end
            end
            tick();
        end
        pmem_resp = 0;
        n_cmp++; if (i_cnt != 1) begin n_bad++; $display("FAIL ionly_iresp_count: got %0d want 1", i_cnt); end
        n_cmp++; if (d_cnt != 0) begin n_bad++; $display("FAIL ionly_dresp_count: got %0d want 0", d_cnt); end
    endtask

    task automatic test_simultaneous();
        logic [LW-1:0] a5 = {32{8'hA5}};
        i_pmem_read = 1; i_pmem_address = 32'h4000;
        d_pmem_write = 1; d_pmem_address = 32'h2000; d_pmem_wdata = a5;
        tick();
        #1;
        n_cmp++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin n_bad++; $display("FAIL sim_dwrite: got rd=%0b wr=%0b want rd=0 wr=1", pmem_read, pmem_write); end
        n_cmp++; if (pmem_wdata !== a5) begin n_bad++; $display("FAIL sim_wdata: got %h want %h", pmem_wdata, a5); end
        d_pmem_address = 32'h3000; d_pmem_wdata = rand_line();
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if (pmem_address !== 32'h2000 || pmem_write !== 1'b1) begin n_bad++; $display("FAIL sim_addr_hold[%0d]: got addr=%h wr=%0b want addr=2000 wr=1", k, pmem_address, pmem_write); end
            tick();
        end
        pmem_resp = 1;
        #1;
        n_cmp++; if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL sim_dresp: got d=%0b i=%0b want d=1 i=0", d_pmem_resp, i_pmem_resp); end
        d_pmem_write = 0;
        tick();
        pmem_resp = 0;
        #1;
        n_cmp++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_bad++; $display("FAIL sim_idle_gap: got rd=%0b wr=%0b want 0 0", pmem_read, pmem_write); end
        tick();
        #1;
        n_cmp++; if (pmem_read !== 1'b1 || pmem_address !== 32'h4000) begin n_bad++; $display("FAIL sim_igrant: got rd=%0b addr=%h want rd=1 addr=4000", pmem_read, pmem_address); end
        i_pmem_read = 0; pmem_resp = 1;
        #1;
        n_cmp++; if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL sim_iresp: got i=%0b d=%0b want i=1 d=0", i_pmem_resp, d_pmem_resp); end
        tick();
        pmem_resp = 0;
    endtask

    task automatic test_second_pair();
        logic [AW-1:0] want;
        d_pmem_read = 1; d_pmem_address = 32'h6000;
        tick();
        d_pmem_read = 0; pmem_resp = 1;
        tick();
        pmem_resp = 0;
        i_pmem_read = 1; i_pmem_address = 32'h7000;
        d_pmem_read = 1; d_pmem_address = 32'h8000;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        want = 32'h7000;
`else
        want = 32'h8000;
`endif
        tick();
        #1;
        n_cmp++; if (pmem_read !== 1'b1 || pmem_address !== want) begin n_bad++; $display("FAIL pair_winner: got rd=%0b addr=%h want rd=1 addr=%h", pmem_read, pmem_address, want); end
        i_pmem_read = 0; d_pmem_read = 0; pmem_resp = 1;
        tick();
        pmem_resp = 0;
    endtask

    task automatic test_reset_mid();
        d_pmem_read = 1; d_pmem_address = 32'h5000;
        tick();
        d_pmem_read = 0;
        tick();
        pmem_resp = 1;
        rst = 1;
        #1;
        model_reset();
        n_cmp++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_bad++; $display("FAIL rstmid_cmd: got rd=%0b wr=%0b want 0 0", pmem_read, pmem_write); end
        n_cmp++; if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL rstmid_resp: got d=%0b i=%0b want 0 0", d_pmem_resp, i_pmem_resp); end
        n_cmp++; if (pmem_address !== '0 || pmem_wdata !== '0) begin n_bad++; $display("FAIL rstmid_addr: got %h want 0", pmem_address); end
        @(negedge clk);
        rst = 0; pmem_resp = 0;
        i_pmem_read = 1; i_pmem_address = 32'h900;
        tick();
        #1;
        n_cmp++; if (pmem_read !== 1'b1 || pmem_address !== 32'h900) begin n_bad++; $display("FAIL rstmid_regrant: got rd=%0b addr=%h want rd=1 addr=900", pmem_read, pmem_address); end
        i_pmem_read = 0; pmem_resp = 1;
        #1;
        n_cmp++; if (i_pmem_resp !== 1'b1) begin n_bad++; $display("FAIL rstmid_iresp: got %0b want 1", i_pmem_resp); end
        tick();
        pmem_resp = 0;
    endtask

    task automatic test_stray_resp();
        logic [LW-1:0] wd = rand_line();
        pmem_resp = 1;
        #1;
        n_cmp++; if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin n_bad++; $display("FAIL stray_resp: got i=%0b d=%0b want 0 0", i_pmem_resp, d_pmem_resp); end
        tick();
        pmem_resp = 0;
        #1;
        n_cmp++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin n_bad++; $display("FAIL stray_idle: got rd=%0b wr=%0b want 0 0", pmem_read, pmem_write); end
        d_pmem_write = 1; d_pmem_address = 32'hA000; d_pmem_wdata = wd;
        tick();
        #1;
        n_cmp++; if (pmem_write !== 1'b1 || pmem_address !== 32'hA000 || pmem_wdata !== wd) begin n_bad++; $display("FAIL stray_next: got wr=%0b addr=%h want wr=1 addr=a000", pmem_write, pmem_address); end
        d_pmem_write = 0; pmem_resp = 1;
        tick();
        pmem_resp = 0;
    endtask

    task automatic test_back_to_back();
        bit hist[$];
        int done = 0;
        int cnt  = 0;
        int lat  = $urandom_range(1, 3);
        int runs = 0;
        int gap  = 0;
        i_pmem_read = 1; i_pmem_address = $urandom() & 32'hFFFF_FFE0;
        for (int c = 0; c < 60 && done < 4; c++) begin
            #1;
            hist.push_back(pmem_read === 1'b1);
            if (pmem_read === 1'b1) begin
                cnt++;
                if (cnt == lat) begin
                    pmem_resp = 1; cnt = 0; lat = $urandom_range(1, 3); done++;
                    if (done == 4) i_pmem_read = 0;
                end
            end
            tick();
            pmem_resp = 0;
        end
        i_pmem_read = 0;
        n_cmp++; if (done != 4) begin n_bad++; $display("FAIL b2b_timeout: got %0d transfers want 4", done); end
        for (int k = 1; k < hist.size(); k++) begin
            if (!hist[k]) gap++;
            if (hist[k] && !hist[k-1]) begin
                runs++;
                if (runs > 1) begin
                    n_cmp++; if (gap != 1) begin n_bad++; $display("FAIL b2b_gap[%0d]: got %0d idle cycles want 1", runs, gap); end
                end
            end
            if (hist[k]) gap = 0;
        end
        n_cmp++; if (runs != 4) begin n_bad++; $display("FAIL b2b_runs: got %0d want 4", runs); end
    endtask

    task automatic test_random();
        bit e_rd, e_wr, e_ir, e_dr;
        rst = 1;
        #1;
        model_reset();
        @(negedge clk);
        rst = 0;
        for (int c = 0; c < 400; c++) begin
            i_pmem_read    = ($urandom_range(0, 2) == 0);
            d_pmem_read    = ($urandom_range(0, 2) == 0);
            d_pmem_write   = ($urandom_range(0, 3) == 0);
            i_pmem_address = $urandom();
            d_pmem_address = $urandom();
            d_pmem_wdata   = rand_line();
            pmem_rdata     = rand_line();
            pmem_resp      = ($urandom_range(0, 3) == 0);
            #1;
            e_rd = m_busy && !(m_is_d && m_write);
            e_wr = m_busy && m_is_d && m_write;
            e_ir = m_busy && !m_is_d && pmem_resp;
            e_dr = m_busy && m_is_d && pmem_resp;
            n_cmp++; if (pmem_read !== e_rd || pmem_write !== e_wr) begin n_bad++; $display("FAIL rnd_cmd[%0d]: got rd=%0b wr=%0b want rd=%0b wr=%0b", c, pmem_read, pmem_write, e_rd, e_wr); end
            n_cmp++; if (i_pmem_resp !== e_ir || d_pmem_resp !== e_dr) begin n_bad++; $display("FAIL rnd_resp[%0d]: got i=%0b d=%0b want i=%0b d=%0b", c, i_pmem_resp, d_pmem_resp, e_ir, e_dr); end
            n_cmp++; if (i_pmem_rdata !== pmem_rdata || d_pmem_rdata !== pmem_rdata) begin n_bad++; $display("FAIL rnd_rdata[%0d]: rdata outputs differ from memory data", c); end
            if (m_busy) begin
                n_cmp++; if (pmem_address !== m_addr) begin n_bad++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, pmem_address, m_addr); end
                if (e_wr) begin
                    n_cmp++; if (pmem_wdata !== m_wdata) begin n_bad++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, pmem_wdata, m_wdata); end
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_icache_only();
        test_simultaneous();
        test_second_pair();
        test_reset_mid();
        test_stray_resp();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
